// File: rtl/serial_operand_serializer_if.sv
// Operand handshake plus serial stream/framing bundle between the operand
// producer, the serializer and the bit-serial adder/sum collector.
interface serial_operand_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             a;
    logic             b;
    logic             adder_rst;
    logic             bit_valid;
    logic             first_bit;
    logic             last_bit;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, a, b, adder_rst, bit_valid, first_bit, last_bit
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, a, b, adder_rst, bit_valid, first_bit, last_bit
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// Captures an operand pair and streams it LSB-first to a bit-serial adder,
// preceded by one carry-clear cycle, with framing strobes for the collector.
module serial_operand_serializer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_operand_serializer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic             ready_s;
    logic             load_s;
    logic             shifting_s;
    logic             last_s;

    assign shifting_s = (state_r == S_SHIFT);
    assign last_s     = shifting_s && (cnt_r == CW'(WIDTH - 1));
    assign load_s     = bus.in_valid && ready_s && !rst;

    // Next-state and ready decode; ready opens in IDLE and on the final bit only.
    always_comb begin
        state_s = state_r;
        ready_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                ready_s = 1'b1;
                if (bus.in_valid) begin
                    state_s = S_CLEAR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_s = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_s) begin
                    ready_s = 1'b1;
                    if (bus.in_valid) begin
                        state_s = S_CLEAR;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    state_s = S_SHIFT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, bit counter and operand shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == S_CLEAR) begin
                cnt_r <= {CW{1'b0}};
            end else if (shifting_s) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // A load on the last bit wins over the final shift.
            if (load_s) begin
                sa_r <= bus.in_a;
                sb_r <= bus.in_b;
            end else if (shifting_s) begin
                sa_r <= sa_r >> 1;
                sb_r <= sb_r >> 1;
            end else begin
                sa_r <= sa_r;
                sb_r <= sb_r;
            end
        end
    end

    // Outputs are forced to their idle/clear values for as long as rst is held,
    // so an abandoned word never leaks a partial bit to the adder.
    assign bus.in_ready  = ready_s && !rst;
    assign bus.adder_rst = rst || !shifting_s;
    assign bus.bit_valid = shifting_s && !rst;
    assign bus.a         = bus.bit_valid && sa_r[0];
    assign bus.b         = bus.bit_valid && sb_r[0];
    assign bus.first_bit = bus.bit_valid && (cnt_r == {CW{1'b0}});
    assign bus.last_bit  = bus.bit_valid && last_s;
endmodule

// File: tb/tb_serial_operand_serializer.sv
// Randomized bench: a word-level reference (captured operands, bit index,
// serial adder) checks every cycle of the serializer's stream and framing.
module tb_serial_operand_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_operand_serializer_if #(.WIDTH(W)) bus_if ();
    serial_operand_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;
    int hs_count = 0;
    int cyc = 0;
    int hs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: phase -1 idle, 0 carry-clear cycle, 1..W carrying bit phase-1.
    int           phase = -1;
    logic [W-1:0] cur_a, cur_b, sum_acc;
    logic [W:0]   full_sum;
    logic         carry_m = 1'b0;
    logic         exp_ready;
    logic         sbit;

    always @(negedge clk) begin
        int i;
        cyc++;
        sbit = bus_if.a ^ bus_if.b ^ carry_m;
        if (rst) begin
            chk("rst_in_ready", bus_if.in_ready, 1'b0);
            chk("rst_adder_rst", bus_if.adder_rst, 1'b1);
            chk("rst_bit_valid", bus_if.bit_valid, 1'b0);
            chk("rst_ab_frame", {bus_if.a, bus_if.b, bus_if.first_bit, bus_if.last_bit}, 4'b0000);
            phase = -1;
        end else begin
            exp_ready = (phase < 0) || (phase == W);
            chk("in_ready", bus_if.in_ready, exp_ready);
            if (phase == 0) begin
                chk("clr_adder_rst", bus_if.adder_rst, 1'b1);
                chk("clr_bit_valid", bus_if.bit_valid, 1'b0);
                chk("clr_ab", {bus_if.a, bus_if.b}, 2'b00);
                phase = 1;
            end else if (phase > 0) begin
                i = phase - 1;
                chk("bit_valid", bus_if.bit_valid, 1'b1);
                chk("shift_adder_rst", bus_if.adder_rst, 1'b0);
                chk("a_bit", bus_if.a, cur_a[i]);
                chk("b_bit", bus_if.b, cur_b[i]);
                chk("first_bit", bus_if.first_bit, (i == 0));
                chk("last_bit", bus_if.last_bit, (i == W - 1));
                sum_acc[i] = sbit;
                if (i == W - 1) begin
                    full_sum = {1'b0, cur_a} + {1'b0, cur_b};
                    chk("word_sum", sum_acc, full_sum[W-1:0]);
                    phase = -1;
                end else begin
                    phase = phase + 1;
                end
            end else begin
                chk("idle_bit_valid", bus_if.bit_valid, 1'b0);
                chk("idle_adder_rst", bus_if.adder_rst, 1'b1);
            end
            if (bus_if.in_valid && exp_ready) begin
                cur_a = bus_if.in_a;
                cur_b = bus_if.in_b;
                phase = 0;
                hs_count++;
                hs_cyc.push_back(cyc);
            end
        end
        carry_m = bus_if.adder_rst ? 1'b0
                : ((bus_if.a & bus_if.b) | (bus_if.a & carry_m) | (bus_if.b & carry_m));
    end

    task automatic scramble();
        bus_if.in_a = W'($urandom);
        bus_if.in_b = W'($urandom);
    endtask

    // Presents an operand pair until accepted; inputs are scrambled on return.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input bit keep_valid);
        int target;
        int k;
        target = hs_count + 1;
        k = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_a = va;
        bus_if.in_b = vb;
        while (hs_count < target && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (hs_count < target) chk("handshake_timeout", 32'd0, 32'd1);
        bus_if.in_valid = keep_valid;
        scramble();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            scramble();
        end
    endtask

    initial begin
        int target;
        int k;
        rst = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_a = 8'h5A;
        bus_if.in_b = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        idle_cycles(2);

        // Single word; operands change every cycle while it is in flight.
        send(8'h0B, 8'h06, 1'b0);
        idle_cycles(W + 3);

        // Back-to-back: carry of FF+01 must not leak into 03+04.
        send(8'hFF, 8'h01, 1'b1);
        bus_if.in_a = 8'h03;
        bus_if.in_b = 8'h04;
        send(8'h03, 8'h04, 1'b0);
        chk("b2b_spacing", hs_cyc[$] - hs_cyc[$-1], W + 1);
        idle_cycles(W + 3);

        // Reset while bit 2 is on the stream, then a clean word.
        send(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        send(8'h05, 8'h05, 1'b0);
        idle_cycles(W + 3);

        // Randomized traffic with random valid gaps, including max-value operands.
        target = hs_count + 200;
        k = 0;
        while (hs_count < target && k < 20000) begin
            bus_if.in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                bus_if.in_a = 8'hFF;
                bus_if.in_b = W'($urandom);
            end else begin
                scramble();
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus_if.in_valid = 1'b0;
        chk("random_words", hs_count, target);
        idle_cycles(W + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
- Upstream feeder for the bit-serial adder. Accepts a pair of WIDTH-bit operands through a valid/ready handshake.
- Emits the operands LSB-first as a contiguous bit stream on a/b, one bit per clock.
- Drives the adder's carry clear (adder_rst) so every word starts with carry = 0.
- Also produces framing strobes (bit_valid, first_bit, last_bit) for the downstream sum collector.

Parameters:
- WIDTH, 8, operand width in bits (≥ 2).
- CW, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair in_a/in_b is valid.
- in_ready  output  1  block accepts the operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- a  output  1  serial bit of A, to the adder's a input.
- b  output  1  serial bit of B, to the adder's b input.
- adder_rst  output  1  carry clear for the adder; connect to the adder's rst.
- bit_valid  output  1  a/b carry a real operand bit this cycle.
- first_bit  output  1  bit 0 of the word is on a/b.
- last_bit  output  1  bit WIDTH-1 of the word is on a/b.

Behaviour:
- Reset (rst high at posedge):
  - state = IDLE; counter = 0; shift registers sa, sb = 0.
  - While rst is high: in_ready = 0, adder_rst = 1, a = b = bit_valid = first_bit = last_bit = 0.
- States: IDLE, CLEAR, SHIFT.
- IDLE:
  - in_ready = 1, adder_rst = 1, bit_valid = 0, a = b = 0.
  - On in_valid & in_ready: load sa = in_a, sb = in_b, go to CLEAR.
- CLEAR:
  - Lasts exactly one cycle. adder_rst = 1, bit_valid = 0, in_ready = 0, a = b = 0.
  - Next state SHIFT, counter = 0.
- SHIFT:
  - adder_rst = 0, bit_valid = 1, a = sa[0], b = sb[0].
  - Each cycle: sa, sb shift right by 1 (zero fill), counter increments.
  - first_bit = (counter == 0); last_bit = (counter == WIDTH-1).
- Leaving SHIFT (counter == WIDTH-1):
  - in_ready = 1 in this cycle only.
  - If in_valid: load the new operands and go to CLEAR (back-to-back).
  - Otherwise: go to IDLE.
- Latency: handshake at edge t → CLEAR at cycle t+1 → bits 0..WIDTH-1 on cycles t+2..t+1+WIDTH.
- Throughput: one word per WIDTH+1 cycles.
- Contiguity is mandatory:
  - The adder has no enable; an idle cycle with a = b = 0 would corrupt the carry.
  - Once SHIFT starts, all WIDTH bits are emitted on consecutive cycles. There is no stall input.
- Operand hold: in_a/in_b are sampled only at the handshake edge. Later changes on the inputs do not affect the word in flight.
- in_valid high outside the ready windows: ignored; the producer holds it until ready.
- Reset mid-word: the word is abandoned immediately. Outputs take their reset values on the next cycle and no partial bits are emitted afterwards.
- The sum bit of word bit i is valid at the adder output in the same cycle as bit i on a/b (combinational adder output).
- Only a^b^carry math is downstream; this block performs no arithmetic.

Test Plan:
- Reset: hold rst 3 cycles with in_valid = 1 → in_ready = 0, adder_rst = 1, bit_valid = 0 throughout. First IDLE cycle after release → in_ready = 1.
- Single word, WIDTH=4, in_a = 4'b1011, in_b = 4'b0110, handshake at edge t:
  - Cycle t+1 → adder_rst = 1.
  - Cycles t+2..t+5 → a = 1,1,0,1 and b = 0,1,1,0.
  - first_bit on t+2, last_bit on t+5.
  - Adder sum = 1,0,0,0 (17 mod 16 = 1).
- Back-to-back, WIDTH=4: in_valid held with 4'hF + 4'h1 then 4'h3 + 4'h4:
  - Second handshake on the last_bit cycle of the first word, followed by exactly one CLEAR cycle.
  - Sums collected: 0 then 7. The carry from 0xF+0x1 does not leak into the second word.
- Operand change in flight: change in_a/in_b every cycle after the handshake → the serial bits still match the values captured at the handshake.
- Reset mid-word: assert rst while bit 2 of 4 is on a/b → next cycle bit_valid = 0, adder_rst = 1. After release, a fresh 4'h5 + 4'h5 gives sum 4'hA.
- Randomised: 200 words, WIDTH=8, random in_valid gaps → reassembled sums equal (in_a + in_b) mod 256. bit_valid is never low between first_bit and last_bit.
